// File: rtl/stream_checker.sv
// stream_checker: in-fabric response checker.
// Expected words are queued from a stimulus source. Actual words from a DUT
// stream are popped in order and compared against the queue head. The block
// reports saturating pass/fail counts, the first mismatching pair and a
// sticky stall timeout.
module stream_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [DATA_WIDTH-1:0] act_data,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  error_pulse,
  output logic [DATA_WIDTH-1:0] first_exp,
  output logic [DATA_WIDTH-1:0] first_act,
  output logic                  timeout_flag,
  output logic                  idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TMO
  } state_t;

  state_t                state;
  logic [SW-1:0]         stall_cnt;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  becomes_empty;
  logic                  match;

  // The extra wrap bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // No bypass: an empty queue never offers act_ready, even while a push fires.
  assign exp_ready = !full;
  assign act_ready = !empty;

  // clear discards any handshake presented in the same cycle.
  assign push_fire     = exp_valid && exp_ready && !clear;
  assign pop_fire      = act_valid && act_ready && !clear;
  assign becomes_empty = pop_fire && !push_fire && (count == (AW+1)'(1));

  assign head  = mem[rd_ptr[AW-1:0]];
  assign match = (act_data == head);

  assign idle = empty && (state == S_IDLE);

  // Queue storage written on every accepted expected word.
  // NOTE: the storage array has no reset; validity is tracked by the pointers,
  // so stale contents after reset or clear are never observed.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[AW-1:0]] <= exp_data;
    end
  end

  // Read and write pointers; clear flushes the queue.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Registered compare result: saturating counters, mismatch pulse, first pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count  <= '0;
      fail_count  <= '0;
      error_pulse <= 1'b0;
      first_exp   <= '0;
      first_act   <= '0;
    end else if (clear) begin
      pass_count  <= '0;
      fail_count  <= '0;
      error_pulse <= 1'b0;
      first_exp   <= '0;
      first_act   <= '0;
    end else begin
      error_pulse <= 1'b0;
      if (pop_fire) begin
        if (match) begin
          if (pass_count != '1) pass_count <= pass_count + CNT_WIDTH'(1);
        end else begin
          error_pulse <= 1'b1;
          if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
          if (fail_count == '0) begin
            first_exp <= head;
            first_act <= act_data;
          end
        end
      end
    end
  end

  // Stall-watch FSM: counts cycles without a pop while words are outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      stall_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else if (clear) begin
      state        <= S_IDLE;
      stall_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          stall_cnt <= '0;
          if (push_fire) state <= S_WAIT;
        end
        S_WAIT: begin
          if (pop_fire) begin
            stall_cnt <= '0;
            if (becomes_empty) state <= S_IDLE;
          end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
            state        <= S_TMO;
            timeout_flag <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        S_TMO: begin
          stall_cnt <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: randomized and directed stimulus; a monitor keeps a
// queue-based reference model and compares every DUT output each cycle.
module tb_stream_checker;

  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CW      = 4;
  localparam int MAXC    = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          exp_valid;
  logic          exp_ready;
  logic [DW-1:0] exp_data;
  logic          act_valid;
  logic          act_ready;
  logic [DW-1:0] act_data;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] fail_count;
  logic          error_pulse;
  logic [DW-1:0] first_exp;
  logic [DW-1:0] first_act;
  logic          timeout_flag;
  logic          idle;

  int total = 0;
  int bad   = 0;

  stream_checker #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .exp_valid   (exp_valid),
    .exp_ready   (exp_ready),
    .exp_data    (exp_data),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_data    (act_data),
    .pass_count  (pass_count),
    .fail_count  (fail_count),
    .error_pulse (error_pulse),
    .first_exp   (first_exp),
    .first_act   (first_act),
    .timeout_flag(timeout_flag),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // ---------------- reference model (state visible in the current cycle) ---
  logic [DW-1:0] m_q[$];
  int            m_pass, m_fail, m_stall;
  bit            m_err, m_tmo;
  logic [DW-1:0] m_fexp, m_fact;
  int            occ;
  bit            pf, af;
  logic [DW-1:0] h;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pass = 0; m_fail = 0; m_stall = 0;
    m_err = 0; m_tmo = 0; m_fexp = '0; m_fact = '0;
  endtask

  // Monitor: compare outputs against the model, then advance the model with
  // the handshakes presented this cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("rst_exp_ready", exp_ready, 1);
      check("rst_act_ready", act_ready, 0);
      check("rst_idle", idle, 1);
      check("rst_pass", pass_count, 0);
      check("rst_fail", fail_count, 0);
      check("rst_err", error_pulse, 0);
      check("rst_tmo", timeout_flag, 0);
    end else begin
      check("exp_ready", exp_ready, m_q.size() < DEPTH);
      check("act_ready", act_ready, m_q.size() > 0);
      check("idle", idle, (m_q.size() == 0) && !m_tmo);
      check("pass_count", pass_count, m_pass);
      check("fail_count", fail_count, m_fail);
      check("error_pulse", error_pulse, m_err);
      check("first_exp", first_exp, m_fexp);
      check("first_act", first_act, m_fact);
      check("timeout_flag", timeout_flag, m_tmo);
      if (clear) begin
        model_reset();
      end else begin
        occ   = m_q.size();
        pf    = exp_valid && (occ < DEPTH);
        af    = act_valid && (occ > 0);
        m_err = 0;
        if (af) begin
          h = m_q.pop_front();
          if (h == act_data) begin
            m_pass = sat(m_pass);
          end else begin
            if (m_fail == 0) begin
              m_fexp = h;
              m_fact = act_data;
            end
            m_fail = sat(m_fail);
            m_err  = 1;
          end
        end
        if (pf) m_q.push_back(exp_data);
        // A stall is a cycle with words outstanding and no pop.
        if (!m_tmo && occ > 0) begin
          if (af) m_stall = 0;
          else if (m_stall == TIMEOUT - 1) m_tmo = 1;
          else m_stall++;
        end else begin
          m_stall = 0;
        end
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; exp_valid = 0; act_valid = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear = 1; tick(); clear = 0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    exp_valid = 1; exp_data = d; tick(); exp_valid = 0;
  endtask

  task automatic act_word(input logic [DW-1:0] d);
    act_valid = 1; act_data = d; tick(); act_valid = 0;
  endtask

  task automatic spot(input string name, input logic [63:0] got_unused, input logic [63:0] want);
    @(negedge clk);
    #1;
    check(name, got_unused, want);
  endtask

  logic [DW-1:0] words[3];

  initial begin
    rst_n = 0; exp_data = '0; act_data = '0;
    idle_inputs();
    repeat (3) tick();
    rst_n = 1;
    tick();

    // 1: three matching words
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) push_word(words[i]);
    for (int i = 0; i < 3; i++) act_word(words[i]);
    tick();
    @(negedge clk);
    check("t1_pass", pass_count, 3);
    check("t1_fail", fail_count, 0);
    check("t1_idle", idle, 1);
    tick();

    // 2: mismatches, first pair held
    do_clear();
    push_word(32'hA5);
    act_word(32'h5A);
    @(negedge clk);
    check("t2_err_pulse", error_pulse, 1);
    check("t2_first_exp", first_exp, 32'hA5);
    check("t2_first_act", first_act, 32'h5A);
    tick();
    push_word(32'h01);
    act_word(32'h02);
    @(negedge clk);
    check("t2_fail2", fail_count, 2);
    check("t2_first_exp_hold", first_exp, 32'hA5);
    tick();

    // 3: fill to full, push+pop while full, drain in order
    do_clear();
    for (int i = 0; i < DEPTH; i++) push_word(DW'(32'h100 + i));
    @(negedge clk);
    check("t3_full", exp_ready, 0);
    tick();
    exp_valid = 1; exp_data = 32'h1FF; act_valid = 1; act_data = 32'h100;
    @(negedge clk);
    check("t3_full_pushpop", exp_ready, 0);
    tick();
    act_data = 32'h101;
    tick();
    exp_valid = 0;
    for (int i = 2; i < DEPTH; i++) act_word(DW'(32'h100 + i));
    act_word(32'h1FF);
    tick();
    @(negedge clk);
    check("t3_pass", pass_count, 9);
    check("t3_idle", idle, 1);
    tick();

    // 4: stall timeout, flag sticky, cleared by clear
    do_clear();
    push_word(32'h44);
    repeat (TIMEOUT) tick();
    @(negedge clk);
    check("t4_tmo", timeout_flag, 1);
    tick();
    act_word(32'h44);
    tick();
    @(negedge clk);
    check("t4_pass", pass_count, 1);
    check("t4_tmo_sticky", timeout_flag, 1);
    check("t4_not_idle", idle, 0);
    tick();
    do_clear();
    @(negedge clk);
    check("t4_clr_tmo", timeout_flag, 0);
    check("t4_clr_idle", idle, 1);
    tick();

    // 5: no bypass on an empty queue
    act_valid = 1; act_data = 32'h77;
    for (int c = 1; c <= 5; c++) begin
      exp_valid = (c == 3); exp_data = 32'h77;
      @(negedge clk);
      check($sformatf("t5_act_ready_c%0d", c), act_ready, c == 4);
      tick();
    end
    idle_inputs();
    tick();

    // 6: asynchronous reset mid-stream
    do_clear();
    for (int i = 0; i < 4; i++) push_word(DW'(i + 1));
    act_word(32'hFF);
    @(negedge clk);
    check("t6_fail_before", fail_count, 1);
    tick();
    rst_n = 0;
    #1;
    check("t6_exp_ready", exp_ready, 1);
    check("t6_act_ready", act_ready, 0);
    check("t6_fail", fail_count, 0);
    check("t6_pass", pass_count, 0);
    check("t6_idle", idle, 1);
    tick();
    rst_n = 1;
    tick();

    // Random phase: bursty pushes/pops, long stalls, occasional clear.
    for (int r = 0; r < 60; r++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int c = 0; c < 30; c++) begin
        exp_data  = DW'($urandom_range(0, 3));
        act_data  = DW'($urandom_range(0, 3));
        clear     = (mode == 3) && ($urandom_range(0, 29) == 0);
        case (mode)
          0: begin exp_valid = ($urandom_range(0, 9) < 8); act_valid = ($urandom_range(0, 9) < 3); end
          1: begin exp_valid = ($urandom_range(0, 9) < 3); act_valid = ($urandom_range(0, 9) < 8); end
          2: begin exp_valid = ($urandom_range(0, 9) < 2); act_valid = 0; end
          default: begin exp_valid = $urandom_range(0, 1); act_valid = $urandom_range(0, 1); end
        endcase
        tick();
      end
      idle_inputs();
    end

    idle_inputs();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
